// File: rtl/pipe_pkg.sv
// Types and constants shared by the forwarding/hazard logic of the 5-stage core.
package pipe_pkg;

  localparam int RA_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            is_load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one source operand against the EX and MEM scoreboard entries.
module fwd_match
  import pipe_pkg::*;
(
  input  logic [RA_W-1:0] i_src,
  input  logic            i_use,
  input  sb_entry_t       i_ex,
  input  sb_entry_t       i_mem,
  output fwd_t            o_code,
  output logic            o_ex_load_hit,
  output logic            o_ex_hit,
  output logic            o_mem_hit
);

  logic w_src_live;

  // x0 is hard-wired zero, so it never produces a dependency
  assign w_src_live = i_use && (i_src != '0);

  assign o_ex_hit      = w_src_live && i_ex.valid  && i_ex.we  && (i_ex.rd  == i_src);
  assign o_mem_hit     = w_src_live && i_mem.valid && i_mem.we && (i_mem.rd == i_src);
  assign o_ex_load_hit = o_ex_hit && i_ex.is_load;

  always_comb begin
    o_code = FWD_NONE;
    if (o_ex_hit)
      o_code = FWD_MEM;
    else if (o_mem_hit)
      o_code = FWD_WB;
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-operand forwarding select and load-use/branch stall control, with a
// shadow EX/MEM/WB destination scoreboard.
module fwd_hazard_unit #(
  parameter int RA_W  = pipe_pkg::RA_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  input  logic             flush,
  input  logic             mem_stall,
  output logic [1:0]       rs1_forwarding,
  output logic [1:0]       rs2_forwarding,
  output logic             stall_if,
  output logic             stall_id,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cycles
);
  import pipe_pkg::*;

  sb_entry_t        r_ex, r_mem, r_wb;
  fwd_t             r_fwd1, r_fwd2;
  logic             r_bubble;
  logic [CNT_W-1:0] r_cnt;

  fwd_t w_code1, w_code2;
  logic w_exl1, w_exl2, w_ex1, w_ex2, w_mem1, w_mem2;
  logic w_hz, w_adv;

  fwd_match u_m1 (
    .i_src(id_rs1), .i_use(id_use_rs1), .i_ex(r_ex), .i_mem(r_mem),
    .o_code(w_code1), .o_ex_load_hit(w_exl1), .o_ex_hit(w_ex1), .o_mem_hit(w_mem1)
  );

  fwd_match u_m2 (
    .i_src(id_rs2), .i_use(id_use_rs2), .i_ex(r_ex), .i_mem(r_mem),
    .o_code(w_code2), .o_ex_load_hit(w_exl2), .o_ex_hit(w_ex2), .o_mem_hit(w_mem2)
  );

  // Branch compare has no forwarding path, so it waits until the producer reaches WB
  assign w_hz = id_valid && !flush &&
                (id_is_branch ? (w_ex1 || w_ex2 || w_mem1 || w_mem2)
                              : (w_exl1 || w_exl2));
  assign w_adv = id_valid && !w_hz && !flush;

  assign stall_if = w_hz || mem_stall;
  assign stall_id = w_hz || mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex     <= '0;
      r_mem    <= '0;
      r_wb     <= '0;
      r_fwd1   <= FWD_NONE;
      r_fwd2   <= FWD_NONE;
      r_bubble <= 1'b1;
      r_cnt    <= '0;
    end else if (!mem_stall) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_adv) begin
        r_ex     <= '{valid: 1'b1, rd: id_rd, we: id_we, is_load: id_is_load};
        r_fwd1   <= w_code1;
        r_fwd2   <= w_code2;
        r_bubble <= 1'b0;
      end else begin
        r_ex     <= '0;
        r_fwd1   <= FWD_NONE;
        r_fwd2   <= FWD_NONE;
        r_bubble <= 1'b1;
      end
      if (w_hz && (r_cnt != '1))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign rs1_forwarding = r_fwd1;
  assign rs2_forwarding = r_fwd2;
  assign ex_bubble      = r_bubble;
  assign stall_cycles   = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_we, id_is_load, id_is_branch;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        flush, mem_stall;
  logic [1:0]  rs1_forwarding, rs2_forwarding;
  logic        stall_if, stall_id, ex_bubble;
  logic [31:0] stall_cycles;
  logic [1:0]  s_rs1_fwd, s_rs2_fwd;
  logic        s_stall_if, s_stall_id, s_ex_bubble;
  logic [1:0]  s_stall_cycles;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .flush(flush),
    .mem_stall(mem_stall), .rs1_forwarding(rs1_forwarding),
    .rs2_forwarding(rs2_forwarding), .stall_if(stall_if), .stall_id(stall_id),
    .ex_bubble(ex_bubble), .stall_cycles(stall_cycles)
  );

  fwd_hazard_unit #(.RA_W(5), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_we(id_we),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .flush(flush),
    .mem_stall(mem_stall), .rs1_forwarding(s_rs1_fwd),
    .rs2_forwarding(s_rs2_fwd), .stall_if(s_stall_if), .stall_id(s_stall_id),
    .ex_bubble(s_ex_bubble), .stall_cycles(s_stall_cycles)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we, ld, br;
  } ins_t;

  typedef struct {
    string      nm;
    bit         st;
    logic [1:0] f1, f2;
    bit         bub;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic ins_t nop();
    return '0;
  endfunction
  function automatic ins_t alu(input int rd, input int r1, input int r2);
    return '{v: 1, rs1: 5'(r1), rs2: 5'(r2), u1: 1, u2: 1, rd: 5'(rd), we: 1, ld: 0, br: 0};
  endfunction
  function automatic ins_t ld(input int rd, input int r1);
    return '{v: 1, rs1: 5'(r1), rs2: 5'd0, u1: 1, u2: 0, rd: 5'(rd), we: 1, ld: 1, br: 0};
  endfunction
  function automatic ins_t br(input int r1, input int r2);
    return '{v: 1, rs1: 5'(r1), rs2: 5'(r2), u1: 1, u2: 1, rd: 5'd0, we: 0, ld: 0, br: 1};
  endfunction

  function automatic void chk(input string nm, input string fld, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s.%s got=%0d expected=%0d (t=%0t)", nm, fld, got, exp, $time);
    end
  endfunction

  // Registered expectations describe the state left by the previous edge;
  // the stall expectation is for this cycle's inputs.
  task automatic cyc(input ins_t in, input bit fl, input bit ms, input bit r,
                     input string nm, input bit es, input int f1, input int f2,
                     input bit eb, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = in.v;
    id_rs1       = in.rs1;
    id_rs2       = in.rs2;
    id_use_rs1   = in.u1;
    id_use_rs2   = in.u2;
    id_rd        = in.rd;
    id_we        = in.we;
    id_is_load   = in.ld;
    id_is_branch = in.br;
    flush        = fl;
    mem_stall    = ms;
    e.nm = nm; e.st = es; e.f1 = 2'(f1); e.f2 = 2'(f2); e.bub = eb; e.cnt = ec;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "stall_if", int'(stall_if), int'(e.st));
      chk(e.nm, "stall_id", int'(stall_id), int'(e.st));
      chk(e.nm, "rs1_fwd", int'(rs1_forwarding), int'(e.f1));
      chk(e.nm, "rs2_fwd", int'(rs2_forwarding), int'(e.f2));
      chk(e.nm, "ex_bubble", int'(ex_bubble), int'(e.bub));
      chk(e.nm, "stall_cycles", int'(stall_cycles), e.cnt);
      chk(e.nm, "sat_cycles", int'(s_stall_cycles), (e.cnt > 3) ? 3 : e.cnt);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t c;
    rst = 1'b1;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_we = 0; id_is_load = 0; id_is_branch = 0; flush = 0; mem_stall = 0;
    repeat (2) @(posedge clk);

    //         instr           fl ms rst name          st f1 f2 bub cnt
    cyc(nop(),            0, 0, 0, "reset",       0, 0, 0, 1, 0);
    cyc(alu(5, 1, 2),     0, 0, 0, "alu_prod",    0, 0, 0, 1, 0);
    cyc(alu(6, 5, 5),     0, 0, 0, "alu_cons",    0, 0, 0, 0, 0);
    cyc(alu(5, 1, 2),     0, 0, 0, "b2b_fwd1",    0, 1, 1, 0, 0);
    cyc(alu(8, 10, 11),   0, 0, 0, "indep",       0, 0, 0, 0, 0);
    cyc(alu(6, 5, 5),     0, 0, 0, "gap_cons",    0, 0, 0, 0, 0);
    cyc(nop(),            0, 0, 0, "gap_fwd2",    0, 2, 2, 0, 0);
    cyc(ld(7, 2),         0, 0, 0, "ld_issue",    0, 0, 0, 1, 0);
    cyc(alu(9, 7, 1),     0, 0, 0, "ld_use_stl",  1, 0, 0, 0, 0);
    cyc(alu(9, 7, 1),     0, 0, 0, "ld_use_rel",  0, 0, 0, 1, 1);
    cyc(nop(),            0, 0, 0, "ld_use_fwd",  0, 2, 0, 0, 1);
    cyc(alu(3, 1, 2),     0, 0, 0, "br_prod",     0, 0, 0, 1, 1);
    cyc(br(3, 4),         0, 0, 0, "br_stl_ex",   1, 0, 0, 0, 1);
    cyc(br(3, 4),         0, 0, 0, "br_stl_mem",  1, 0, 0, 1, 2);
    cyc(br(3, 4),         0, 0, 0, "br_rel",      0, 0, 0, 1, 3);
    cyc(nop(),            0, 0, 0, "br_in_ex",    0, 0, 0, 0, 3);
    cyc(alu(3, 1, 2),     0, 0, 0, "br2_prod",    0, 0, 0, 1, 3);
    cyc(alu(8, 10, 11),   0, 0, 0, "br2_indep",   0, 0, 0, 0, 3);
    cyc(br(3, 4),         0, 0, 0, "br2_stl",     1, 0, 0, 0, 3);
    cyc(br(3, 4),         0, 0, 0, "br2_rel",     0, 0, 0, 1, 4);
    cyc(nop(),            0, 0, 0, "br2_in_ex",   0, 0, 0, 0, 4);
    cyc(ld(0, 1),         0, 0, 0, "ld_x0",       0, 0, 0, 1, 4);
    cyc(alu(10, 0, 0),    0, 0, 0, "use_x0",      0, 0, 0, 0, 4);
    cyc(ld(9, 1),         0, 0, 0, "ld_x9",       0, 0, 0, 0, 4);
    c = alu(11, 1, 9);
    c.u2 = 1'b0;
    cyc(c,                0, 0, 0, "unused_rs2",  0, 0, 0, 0, 4);
    cyc(nop(),            0, 0, 0, "unused_ex",   0, 0, 0, 0, 4);
    cyc(ld(7, 2),         0, 0, 0, "fl_ld",       0, 0, 0, 1, 4);
    cyc(alu(9, 7, 7),     1, 0, 0, "fl_cancel",   0, 0, 0, 0, 4);
    cyc(alu(9, 7, 7),     0, 0, 0, "fl_refetch",  0, 0, 0, 1, 4);
    cyc(alu(12, 9, 9),    1, 0, 0, "fl_alu",      0, 2, 2, 0, 4);
    cyc(alu(12, 9, 1),    0, 0, 0, "fl_codes0",   0, 0, 0, 1, 4);
    cyc(ld(13, 1),        0, 0, 0, "ms_ld",       0, 2, 0, 0, 4);
    cyc(alu(14, 13, 12),  0, 1, 0, "ms_frz1",     1, 0, 0, 0, 4);
    cyc(alu(14, 13, 12),  0, 1, 0, "ms_frz2",     1, 0, 0, 0, 4);
    cyc(alu(14, 13, 12),  0, 1, 0, "ms_frz3",     1, 0, 0, 0, 4);
    cyc(alu(14, 13, 12),  0, 0, 0, "ms_hz",       1, 0, 0, 0, 4);
    cyc(alu(14, 13, 12),  0, 0, 0, "ms_rel",      0, 0, 0, 1, 5);
    cyc(nop(),            0, 0, 0, "ms_fwd",      0, 2, 0, 0, 5);
    cyc(alu(3, 1, 2),     0, 0, 0, "rst_prod",    0, 0, 0, 1, 5);
    cyc(br(3, 4),         0, 0, 0, "rst_br_stl",  1, 0, 0, 0, 5);
    cyc(br(3, 4),         0, 0, 1, "rst_async",   0, 0, 0, 1, 0);
    cyc(br(3, 4),         0, 0, 0, "rst_held",    0, 0, 0, 1, 0);
    cyc(nop(),            0, 0, 0, "rst_br_ex",   0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain got=%0d expected=0 pending records", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
